// File: rtl/stack_pkg.sv
// Shared types and constants for the stack pointer unit and its address generator.
package stack_pkg;

    typedef enum logic [1:0] {
        SP_IDLE = 2'd0,
        SP_PUSH = 2'd1,
        SP_PULL = 2'd2
    } sp_state_t;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
    localparam logic       OP_PUSH            = 1'b1;
    localparam logic       OP_PULL            = 1'b0;

endpackage

// File: rtl/stack_addr_gen.sv
// Combinational stack address former: page/zero-extension, pull pre-increment and emulation masking.
module stack_addr_gen
    import stack_pkg::*;
#(
    parameter int unsigned SP_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic [SP_WIDTH-1:0]   sp,
    input  logic                  emu_mode,
    input  logic                  pre_inc,
    output logic [ADDR_WIDTH-1:0] addr_c
);

    logic [SP_WIDTH-1:0] sp_eff;
    logic [7:0]          lo_eff;

    // In page mode only the low byte moves, so the increment must not carry into the page.
    always_comb begin
        sp_eff = sp + SP_WIDTH'(pre_inc);
        lo_eff = sp[7:0] + 8'(pre_inc);
        if ((SP_WIDTH == 8) || emu_mode) begin
            addr_c = ADDR_WIDTH'({STACK_PAGE, lo_eff});
        end else begin
            addr_c = ADDR_WIDTH'(sp_eff);
        end
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with a multi-beat push/pull sequencer and sticky wrap flags.
module stack_pointer_unit
    import stack_pkg::*;
#(
    parameter int unsigned         SP_WIDTH    = 8,
    parameter int unsigned         ADDR_WIDTH  = 16,
    parameter logic [7:0]          STACK_PAGE  = STACK_PAGE_DEFAULT,
    parameter logic [SP_WIDTH-1:0] RESET_VALUE = SP_WIDTH'(8'hFF),
    parameter int unsigned         MAX_BURST   = 3
) (
    input  logic                  fclk,
    input  logic                  reset,
    input  logic                  sp_reset,
    input  logic                  sp_load,
    input  logic [SP_WIDTH-1:0]   db_in,
    output logic [SP_WIDTH-1:0]   db_out,
    input  logic                  emu_mode,
    input  logic                  op_valid,
    input  logic                  op_push,
    input  logic [1:0]            op_count,
    output logic                  op_ready,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] stack_addr,
    output logic                  stack_we,
    output logic                  stack_re,
    output logic [1:0]            beat_idx,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  ovf_flag,
    output logic                  unf_flag,
    input  logic                  flag_clear
);

    localparam int unsigned         CNT_W   = 2;
    localparam logic [SP_WIDTH-1:0] LO_MASK = SP_WIDTH'(8'hFF);
    localparam logic [SP_WIDTH-1:0] PAGE_HI = SP_WIDTH'({STACK_PAGE, 8'h00});

    sp_state_t           state_q, state_d;
    logic [SP_WIDTH-1:0] sp_q, sp_d;
    logic [CNT_W-1:0]    left_q, left_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                byte_mode;
    logic [SP_WIDTH-1:0] move_mask;
    logic [SP_WIDTH-1:0] sp_dec;
    logic [SP_WIDTH-1:0] sp_inc;
    logic                wrap_push;
    logic                wrap_pull;
    logic                count_ok;
    logic                ovf_set;
    logic                unf_set;

    // SP arithmetic: in page mode bits above the low byte are left untouched.
    always_comb begin
        byte_mode = (SP_WIDTH == 8) || emu_mode;
        move_mask = byte_mode ? LO_MASK : '1;
        sp_dec    = (sp_q & ~move_mask) | ((sp_q - SP_WIDTH'(1)) & move_mask);
        sp_inc    = (sp_q & ~move_mask) | ((sp_q + SP_WIDTH'(1)) & move_mask);
        wrap_push = (sp_q & move_mask) == '0;
        wrap_pull = (sp_q & move_mask) == move_mask;
        count_ok  = (op_count != '0) && (32'(op_count) <= MAX_BURST);
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        left_d  = left_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (sp_reset) begin
            state_d = SP_IDLE;
            sp_d    = RESET_VALUE;
            left_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                SP_IDLE: begin
                    if (sp_load) begin
                        sp_d = db_in;
                    end
                    if (op_valid && count_ok) begin
                        state_d = (op_push == OP_PUSH) ? SP_PUSH : SP_PULL;
                        left_d  = op_count;
                        idx_d   = '0;
                    end
                end
                SP_PUSH, SP_PULL: begin
                    if (mem_ready) begin
                        if (state_q == SP_PUSH) begin
                            sp_d    = sp_dec;
                            ovf_set = wrap_push;
                        end else begin
                            sp_d    = sp_inc;
                            unf_set = wrap_pull;
                        end
                        left_d = left_q - CNT_W'(1);
                        idx_d  = idx_q + CNT_W'(1);
                        if (left_q == CNT_W'(1)) begin
                            state_d = SP_IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = SP_IDLE;
            endcase
        end

        // Emulation pins the high byte to the stack page on every edge.
        if ((SP_WIDTH > 8) && emu_mode) begin
            sp_d = (sp_d & LO_MASK) | PAGE_HI;
        end

        ovf_d = (ovf_q & ~flag_clear) | ovf_set;
        unf_d = (unf_q & ~flag_clear) | unf_set;
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q <= SP_IDLE;
            sp_q    <= RESET_VALUE;
            left_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            left_q  <= left_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_addr_gen #(
        .SP_WIDTH  (SP_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .STACK_PAGE(STACK_PAGE)
    ) u_addr_gen (
        .sp      (sp_q),
        .emu_mode(emu_mode),
        .pre_inc (state_q == SP_PULL),
        .addr_c  (stack_addr)
    );

    // Strobes decode straight from state so an async reset drops them immediately.
    assign stack_we = (state_q == SP_PUSH);
    assign stack_re = (state_q == SP_PULL);
    assign op_ready = (state_q == SP_IDLE);
    assign seq_busy = (state_q != SP_IDLE);
    assign db_out   = sp_q;
    assign beat_idx = idx_q;
    assign seq_done = done_q;
    assign ovf_flag = ovf_q;
    assign unf_flag = unf_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed and random checks of an 8-bit and a 16-bit stack_pointer_unit against an integer model.
module tb_stack_pointer_unit;
    import stack_pkg::*;

    logic        fclk = 1'b0;
    logic        reset = 1'b0;
    logic        sp_reset = 1'b0, sp_load = 1'b0, emu_mode = 1'b0, flag_clear = 1'b0;
    logic        op_valid = 1'b0, op_push = 1'b0, mem_ready = 1'b0;
    logic [1:0]  op_count = 2'd0;
    logic [15:0] db_in16 = 16'h0000;

    logic [7:0]  db_out8;
    logic [15:0] db_out16, addr8, addr16;
    logic        op_ready8, op_ready16, we8, we16, re8, re16;
    logic [1:0]  idx8, idx16;
    logic        busy8, busy16, done8, done16, ovf8, ovf16, unf8, unf16;

    int vectors = 0;
    int miscompares = 0;

    int m_sp[2], m_mode[2], m_left[2], m_idx[2], m_done[2], m_ovf[2], m_unf[2];

    always #5 fclk = ~fclk;

    stack_pointer_unit u8 (
        .fclk(fclk), .reset(reset), .sp_reset(sp_reset), .sp_load(sp_load),
        .db_in(db_in16[7:0]), .db_out(db_out8), .emu_mode(emu_mode),
        .op_valid(op_valid), .op_push(op_push), .op_count(op_count), .op_ready(op_ready8),
        .mem_ready(mem_ready), .stack_addr(addr8), .stack_we(we8), .stack_re(re8),
        .beat_idx(idx8), .seq_busy(busy8), .seq_done(done8),
        .ovf_flag(ovf8), .unf_flag(unf8), .flag_clear(flag_clear)
    );

    stack_pointer_unit #(.SP_WIDTH(16), .RESET_VALUE(16'h00FF)) u16 (
        .fclk(fclk), .reset(reset), .sp_reset(sp_reset), .sp_load(sp_load),
        .db_in(db_in16), .db_out(db_out16), .emu_mode(emu_mode),
        .op_valid(op_valid), .op_push(op_push), .op_count(op_count), .op_ready(op_ready16),
        .mem_ready(mem_ready), .stack_addr(addr16), .stack_we(we16), .stack_re(re16),
        .beat_idx(idx16), .seq_busy(busy16), .seq_done(done16),
        .ovf_flag(ovf16), .unf_flag(unf16), .flag_clear(flag_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model state: mode 0=idle, 1=push, 2=pull; index 0 is the 8-bit unit, 1 the 16-bit unit.
    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_sp[k] = 255; m_mode[k] = 0; m_left[k] = 0; m_idx[k] = 0;
            m_done[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
    endtask

    function automatic int exp_addr(input int k);
        int pull;
        pull = (m_mode[k] == 2) ? 1 : 0;
        if (k == 0 || emu_mode) return 256 + (((m_sp[k] & 255) + pull) & 255);
        return (m_sp[k] + pull) & 65535;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int mask, wo, wu, cnt;
            mask = (k == 0 || emu_mode) ? 255 : 65535;
            wo = 0; wu = 0;
            cnt = int'(op_count);
            if (sp_reset) begin
                m_sp[k] = 255; m_mode[k] = 0; m_left[k] = 0; m_idx[k] = 0; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_mode[k] == 0) begin
                    if (sp_load) m_sp[k] = (k == 0) ? int'(db_in16) & 255 : int'(db_in16);
                    if (op_valid && cnt >= 1 && cnt <= 3) begin
                        m_mode[k] = op_push ? 1 : 2; m_left[k] = cnt; m_idx[k] = 0;
                    end
                end else if (mem_ready) begin
                    if (m_mode[k] == 1) begin
                        wo = ((m_sp[k] & mask) == 0) ? 1 : 0;
                        m_sp[k] = (m_sp[k] & ~mask) | ((m_sp[k] - 1) & mask);
                    end else begin
                        wu = ((m_sp[k] & mask) == mask) ? 1 : 0;
                        m_sp[k] = (m_sp[k] & ~mask) | ((m_sp[k] + 1) & mask);
                    end
                    m_left[k]--; m_idx[k]++;
                    if (m_left[k] == 0) begin m_mode[k] = 0; m_idx[k] = 0; m_done[k] = 1; end
                end
            end
            if (k == 1 && emu_mode) m_sp[k] = 256 + (m_sp[k] & 255);
            m_ovf[k] = ((m_ovf[k] != 0 && !flag_clear) || wo != 0) ? 1 : 0;
            m_unf[k] = ((m_unf[k] != 0 && !flag_clear) || wu != 0) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        chk("db_out8", 32'(db_out8), 32'(m_sp[0]));
        chk("addr8", 32'(addr8), 32'(exp_addr(0)));
        chk("we8", 32'(we8), 32'(m_mode[0] == 1));
        chk("re8", 32'(re8), 32'(m_mode[0] == 2));
        chk("ready8", 32'(op_ready8), 32'(m_mode[0] == 0));
        chk("busy8", 32'(busy8), 32'(m_mode[0] != 0));
        chk("idx8", 32'(idx8), 32'(m_idx[0]));
        chk("done8", 32'(done8), 32'(m_done[0]));
        chk("ovf8", 32'(ovf8), 32'(m_ovf[0]));
        chk("unf8", 32'(unf8), 32'(m_unf[0]));
        chk("db_out16", 32'(db_out16), 32'(m_sp[1]));
        chk("addr16", 32'(addr16), 32'(exp_addr(1)));
        chk("we16", 32'(we16), 32'(m_mode[1] == 1));
        chk("re16", 32'(re16), 32'(m_mode[1] == 2));
        chk("ready16", 32'(op_ready16), 32'(m_mode[1] == 0));
        chk("busy16", 32'(busy16), 32'(m_mode[1] != 0));
        chk("idx16", 32'(idx16), 32'(m_idx[1]));
        chk("done16", 32'(done16), 32'(m_done[1]));
        chk("ovf16", 32'(ovf16), 32'(m_ovf[1]));
        chk("unf16", 32'(unf16), 32'(m_unf[1]));
    endtask

    // Called at a falling edge: check, advance model across the rising edge, return at next fall.
    task automatic tick();
        #1 check_all();
        @(posedge fclk);
        model_step();
        @(negedge fclk);
    endtask

    task automatic req(input logic push, input logic [1:0] cnt);
        op_valid = 1'b1; op_push = push; op_count = cnt;
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        // Async reset asserted between edges
        #2 reset = 1'b1;
        #1;
        chk("rst_sp", 32'(db_out8), 32'h00FF);
        chk("rst_addr", 32'(addr8), 32'h01FF);
        chk("rst_ready", 32'(op_ready8), 32'd1);
        chk("rst_strobes", 32'({we8, re8}), 32'd0);
        chk("rst_flags", 32'({ovf8, unf8}), 32'd0);
        m_reset();
        @(negedge fclk);
        reset = 1'b0;

        // Three-beat push from FF
        mem_ready = 1'b1;
        req(OP_PUSH, 2'd3);
        chk("push_b0", 32'(addr8), 32'h01FF);
        chk("push_we", 32'(we8), 32'd1);
        tick();
        chk("push_b1", 32'(addr8), 32'h01FE);
        tick();
        chk("push_b2", 32'(addr8), 32'h01FD);
        tick();
        chk("push_done", 32'(done8), 32'd1);
        chk("push_sp", 32'(db_out8), 32'h00FC);
        tick();
        chk("push_done_clr", 32'(done8), 32'd0);

        // Three-beat pull with a two-cycle stall on beat 1
        req(OP_PULL, 2'd3);
        chk("pull_b0", 32'(addr8), 32'h01FD);
        tick();
        mem_ready = 1'b0;
        chk("pull_b1", 32'(addr8), 32'h01FE);
        tick();
        chk("pull_stall_addr", 32'(addr8), 32'h01FE);
        chk("pull_stall_re", 32'(re8), 32'd1);
        chk("pull_stall_idx", 32'(idx8), 32'd1);
        tick();
        mem_ready = 1'b1;
        chk("pull_stall2_addr", 32'(addr8), 32'h01FE);
        tick();
        chk("pull_b2", 32'(addr8), 32'h01FF);
        tick();
        chk("pull_sp", 32'(db_out8), 32'h00FF);
        chk("pull_done", 32'(done8), 32'd1);

        // Wrap below zero and above max
        sp_load = 1'b1; db_in16 = 16'h0000;
        tick();
        sp_load = 1'b0;
        chk("load_sp", 32'(db_out8), 32'h0000);
        req(OP_PUSH, 2'd1);
        chk("wrap_push_addr", 32'(addr8), 32'h0100);
        tick();
        chk("wrap_push_sp", 32'(db_out8), 32'h00FF);
        chk("wrap_ovf", 32'(ovf8), 32'd1);
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        chk("ovf_cleared", 32'(ovf8), 32'd0);
        req(OP_PULL, 2'd1);
        chk("wrap_pull_addr", 32'(addr8), 32'h0100);
        tick();
        chk("wrap_pull_sp", 32'(db_out8), 32'h0000);
        chk("wrap_unf", 32'(unf8), 32'd1);

        // 16-bit unit entering emulation
        sp_load = 1'b1; db_in16 = 16'h2300;
        tick();
        sp_load = 1'b0;
        chk("w16_load", 32'(db_out16), 32'h2300);
        emu_mode = 1'b1;
        tick();
        chk("w16_emu_page", 32'(db_out16), 32'h0100);
        req(OP_PUSH, 2'd1);
        chk("w16_emu_addr", 32'(addr16), 32'h0100);
        tick();
        chk("w16_emu_sp", 32'(db_out16), 32'h01FF);
        chk("w16_emu_ovf", 32'(ovf16), 32'd1);
        emu_mode = 1'b0;

        // sp_reset aborts a push; sp_load while busy is ignored
        sp_reset = 1'b1; flag_clear = 1'b1;
        tick();
        sp_reset = 1'b0; flag_clear = 1'b0;
        chk("spr_sp", 32'(db_out8), 32'h00FF);
        req(OP_PUSH, 2'd3);
        tick();
        mem_ready = 1'b0; sp_load = 1'b1; db_in16 = 16'h0040;
        tick();
        sp_load = 1'b0;
        chk("busy_load_ignored", 32'(db_out8), 32'h00FE);
        chk("busy_idx", 32'(idx8), 32'd1);
        sp_reset = 1'b1;
        tick();
        sp_reset = 1'b0;
        chk("abort_sp", 32'(db_out8), 32'h00FF);
        chk("abort_idle", 32'(busy8), 32'd0);
        chk("abort_no_done", 32'(done8), 32'd0);
        tick();
        chk("abort_no_done2", 32'(done8), 32'd0);

        // Async reset mid-sequence drops strobes without waiting for an edge
        req(OP_PUSH, 2'd2);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("areset_we", 32'(we8), 32'd0);
        chk("areset_sp", 32'(db_out8), 32'h00FF);
        chk("areset_ready", 32'(op_ready8), 32'd1);
        m_reset();
        @(negedge fclk);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            op_valid   = 1'($urandom_range(0, 1));
            op_push    = 1'($urandom_range(0, 1));
            op_count   = 2'($urandom_range(0, 3));
            mem_ready  = ($urandom_range(0, 3) != 0);
            sp_load    = ($urandom_range(0, 9) == 0);
            sp_reset   = ($urandom_range(0, 39) == 0);
            flag_clear = ($urandom_range(0, 19) == 0);
            db_in16    = 16'($urandom);
            if ($urandom_range(0, 49) == 0) emu_mode = ~emu_mode;
            tick();
        end
        #1 check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
Parametrised stack pointer with a built-in multi-beat push/pull sequencer. It replaces the bare 8-bit latch-based stack pointer register in the 65c02 core. It owns SP and forms the full stack address; in wide mode, an emulation mode pins the high byte to the stack page. The execution FSM hands it 1..MAX_BURST byte push/pull requests (PHA, JSR, BRK/IRQ frames, RTS/RTI) and it sequences the bus beats with a ready handshake.

Parameters:
SP_WIDTH, 8, stack pointer width; legal values 8 or 16.
ADDR_WIDTH, 16, stack address width.
STACK_PAGE, 8'h01, high address byte used when SP_WIDTH=8 or emu_mode=1.
RESET_VALUE, 'hFF, SP value on reset and on sp_reset; width SP_WIDTH.
MAX_BURST, 3, maximum beats per request.

Ports:
fclk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
sp_reset  in  1  synchronous SP reinit to RESET_VALUE; aborts any sequence
sp_load  in  1  load SP from db_in (TXS); honoured in IDLE only
db_in  in  SP_WIDTH  load data
db_out  out  SP_WIDTH  current SP (TSX)
emu_mode  in  1  SP_WIDTH=16 only: pins high byte to STACK_PAGE
op_valid  in  1  request valid
op_push  in  1  1=push, 0=pull
op_count  in  2  beats requested, 1..MAX_BURST
op_ready  out  1  high in IDLE only
mem_ready  in  1  current beat completes this cycle
stack_addr  out  ADDR_WIDTH  address of current beat
stack_we  out  1  push beat active
stack_re  out  1  pull beat active
beat_idx  out  2  index of current beat, 0-based
seq_busy  out  1  state != IDLE
seq_done  out  1  one-cycle pulse after last beat
ovf_flag  out  1  sticky; push wrapped below zero
unf_flag  out  1  sticky; pull wrapped above max
flag_clear  in  1  clears both sticky flags

Behaviour:
- Reset (async): SP=RESET_VALUE, state IDLE, beat_idx=0, beats_left=0. Outputs: stack_we=0, stack_re=0, seq_done=0, ovf_flag=0, unf_flag=0, op_ready=1. stack_addr={STACK_PAGE,8'hFF} for the defaults.
- Control priority per edge: sp_reset > sp_load (IDLE only) > beat completion.
- sp_load while busy is ignored: no SP change, no flag set.
- FSM states are IDLE, PUSH and PULL.
  - IDLE -> PUSH/PULL on op_valid & op_ready with 1 <= op_count <= MAX_BURST. Requests with op_count=0 or op_count > MAX_BURST are dropped silently.
  - stack_we or stack_re asserts the cycle after acceptance (1-cycle latency), beat_idx=0.
- PUSH beat: stack_addr=form(SP). When mem_ready: SP<=SP-1, beat_idx++.
- PULL beat: stack_addr=form(SP+1) (pre-increment). When mem_ready: SP<=SP+1, beat_idx++.
- Without mem_ready, the beat holds: address, SP and strobes are stable.
- Last beat completing: state->IDLE and strobes drop next cycle. seq_done=1 and op_ready=1 in that same cycle.
  - A new request can be accepted in the seq_done cycle.
  - Minimum gap between sequences is 1 idle cycle.
- form(): for SP_WIDTH=8, {STACK_PAGE, sp}. For SP_WIDTH=16, emu_mode=0 gives sp zero-extended to ADDR_WIDTH; emu_mode=1 gives {STACK_PAGE, sp[7:0]}.
- Wrap-around:
  - SP_WIDTH=8: 8'h00 push -> 8'hFF and sets ovf_flag; 8'hFF pull -> 8'h00 and sets unf_flag.
  - SP_WIDTH=16, emu_mode=1: only low byte moves, high byte forced to STACK_PAGE on every update. Low-byte wrap sets the same flags.
  - SP_WIDTH=16, emu_mode=0: full 16-bit wrap sets the flags.
- Flags are sticky until flag_clear or reset. A wrap in the same cycle as flag_clear leaves the flag set (set wins).
- emu_mode rising while SP_WIDTH=16: SP high byte <= STACK_PAGE on the next edge.
- sp_reset mid-sequence: SP=RESET_VALUE, IDLE next cycle, strobes drop, no seq_done. Beats already completed are not undone.
- Async reset mid-sequence: strobes drop immediately (combinational from state).
- db_out always equals the registered SP; no latches anywhere.

Decomposition:
- Package stack_pkg holds sp_state_t enum {SP_IDLE, SP_PUSH, SP_PULL}, the STACK_PAGE_DEFAULT constant and the OP_PUSH/OP_PULL constants.
- One combinational sub-module, stack_addr_gen, implements form(), pull pre-increment and emu masking. It is reused by the future 65816 direct-page path.

Test Plan:
- reset pulse mid-clock -> immediately SP=8'hFF, stack_addr=16'h01FF, op_ready=1, strobes 0, flags 0.
- SP=FF, push op_count=3, mem_ready=1 -> addresses 01FF, 01FE, 01FD on consecutive cycles; final SP=FC; seq_done pulses once.
- SP=FC, pull op_count=3, mem_ready low 2 cycles on beat 1 -> addresses 01FD, 01FE (held 3 cycles), 01FF; final SP=FF; stack_re held stable during the stall.
- SP=00, push count=1 -> stack_addr=0100, SP=FF, ovf_flag=1. Then flag_clear -> ovf_flag=0. Then SP=FF pull -> addr=0100, SP=00, unf_flag=1.
- SP_WIDTH=16, SP=16'h2300, emu_mode 0->1 -> SP=16'h0100; push -> addr 0100, SP=01FF (high byte held), ovf_flag=1.
- sp_reset during beat 2 of 3-beat push from FF -> SP=FF next cycle, IDLE, no seq_done. sp_load=1 with db_in=40 while busy -> ignored.
